// File: rtl/src_bus_arbiter_pkg.sv
// Shared definitions for the source-bus arbiter: FSM encoding, source count
// and the selector codes driven onto the 5:1 source mux.
package src_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_SWITCH = 2'd2
  } arb_state_e;

  localparam int NUM_SRC = 5;

  localparam logic [2:0] SEL_SRC0 = 3'd0;
  localparam logic [2:0] SEL_SRC1 = 3'd1;
  localparam logic [2:0] SEL_SRC2 = 3'd2;
  localparam logic [2:0] SEL_SRC3 = 3'd3;
  localparam logic [2:0] SEL_SRC4 = 3'd4;

  // Selector index to one-hot grant vector; illegal codes map to no grant.
  function automatic logic [4:0] sel_to_onehot(input logic [2:0] sel);
    logic [4:0] oh;
    case (sel)
      SEL_SRC0: oh = 5'b00001;
      SEL_SRC1: oh = 5'b00010;
      SEL_SRC2: oh = 5'b00100;
      SEL_SRC3: oh = 5'b01000;
      SEL_SRC4: oh = 5'b10000;
      default:  oh = 5'b00000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/src_bus_arbiter_mux5.sv
// Combinational 5:1 source mux feeding the shared bus; unused selector codes
// drive zero rather than alias onto a real source.
module src_mux5
  import src_bus_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        selector,
  input  logic [DATA_W-1:0] data_in_0,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic [DATA_W-1:0] data_in_2,
  input  logic [DATA_W-1:0] data_in_3,
  input  logic [DATA_W-1:0] data_in_4,
  output logic [DATA_W-1:0] bus_data
);

  // Source selection.
  always_comb begin
    case (selector)
      SEL_SRC0: bus_data = data_in_0;
      SEL_SRC1: bus_data = data_in_1;
      SEL_SRC2: bus_data = data_in_2;
      SEL_SRC3: bus_data = data_in_3;
      SEL_SRC4: bus_data = data_in_4;
      default:  bus_data = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/src_bus_arbiter.sv
// Round-robin arbiter for the shared datapath transfer bus with bounded
// ownership time and a one-cycle turnaround between owners.
module src_bus_arbiter
  import src_bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [4:0]        req,
  input  logic [DATA_W-1:0] data_in_0,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic [DATA_W-1:0] data_in_2,
  input  logic [DATA_W-1:0] data_in_3,
  input  logic [DATA_W-1:0] data_in_4,
  output logic [4:0]        grant,
  output logic [2:0]        selector,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic [7:0]        hold_cnt
);

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  arb_state_e state_q, state_d;
  logic [4:0] grant_q, grant_d;
  logic [2:0] selector_q, selector_d;
  logic       bus_valid_q, bus_valid_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [2:0] last_owner_q, last_owner_d;
  logic [2:0] pick_s;
  logic       owner_req_s;
  logic       others_req_s;

  // First set request after 'last', wrapping 4 -> 0; 'last' itself is tried last.
  function automatic logic [2:0] rr_pick(input logic [4:0] r, input logic [2:0] last);
    logic [3:0] idx;
    logic       found;
    logic [2:0] win;
    found = 1'b0;
    win   = last;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = {1'b0, last} + 4'(k);
      if (idx >= 4'(NUM_SRC)) begin
        idx = idx - 4'(NUM_SRC);
      end else begin
        idx = idx;
      end
      if (!found && r[idx[2:0]]) begin
        found = 1'b1;
        win   = idx[2:0];
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

  assign pick_s       = rr_pick(req, last_owner_q);
  assign owner_req_s  = |(req & grant_q);
  assign others_req_s = |(req & ~grant_q);

  // Next-state and next-output computation for the arbiter FSM.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    selector_d   = selector_q;
    bus_valid_d  = bus_valid_q;
    hold_cnt_d   = hold_cnt_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ST_IDLE, ST_SWITCH: begin
        if (req != 5'd0) begin
          state_d     = ST_GRANT;
          grant_d     = sel_to_onehot(pick_s);
          selector_d  = pick_s;
          bus_valid_d = 1'b1;
          hold_cnt_d  = 8'd1;
        end else begin
          state_d     = ST_IDLE;
          grant_d     = 5'd0;
          bus_valid_d = 1'b0;
          hold_cnt_d  = 8'd0;
        end
      end
      ST_GRANT: begin
        // Release and preemption collapse into a single turnaround cycle.
        if (!owner_req_s || (hold_cnt_q == MAX_HOLD_C && others_req_s)) begin
          state_d      = ST_SWITCH;
          grant_d      = 5'd0;
          bus_valid_d  = 1'b0;
          hold_cnt_d   = 8'd0;
          last_owner_d = selector_q;
        end else if (hold_cnt_q != MAX_HOLD_C) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end else begin
          hold_cnt_d = hold_cnt_q;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        grant_d      = 5'd0;
        selector_d   = SEL_SRC0;
        bus_valid_d  = 1'b0;
        hold_cnt_d   = 8'd0;
        last_owner_d = SEL_SRC4;
      end
    endcase
  end

  // State and registered outputs; last_owner resets to 4 so requester 0 wins first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= 5'd0;
      selector_q   <= SEL_SRC0;
      bus_valid_q  <= 1'b0;
      hold_cnt_q   <= 8'd0;
      last_owner_q <= SEL_SRC4;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      selector_q   <= selector_d;
      bus_valid_q  <= bus_valid_d;
      hold_cnt_q   <= hold_cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign grant     = grant_q;
  assign selector  = selector_q;
  assign bus_valid = bus_valid_q;
  assign hold_cnt  = hold_cnt_q;

  src_mux5 #(.DATA_W(DATA_W)) u_mux (
    .selector  (selector_q),
    .data_in_0 (data_in_0),
    .data_in_1 (data_in_1),
    .data_in_2 (data_in_2),
    .data_in_3 (data_in_3),
    .data_in_4 (data_in_4),
    .bus_data  (bus_data)
  );

endmodule

// File: tb/tb_src_bus_arbiter.sv
// Directed testbench for src_bus_arbiter with MAX_HOLD=8.
module tb_src_bus_arbiter;

  logic        clk;
  logic        reset_n;
  logic [4:0]  req;
  logic [31:0] data_in_0, data_in_1, data_in_2, data_in_3, data_in_4;
  logic [4:0]  grant;
  logic [2:0]  selector;
  logic        bus_valid;
  logic [31:0] bus_data;
  logic [7:0]  hold_cnt;

  int checks;
  int failures;
  logic [31:0] exp_data [5];

  src_bus_arbiter #(.MAX_HOLD(8), .DATA_W(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .data_in_0 (data_in_0),
    .data_in_1 (data_in_1),
    .data_in_2 (data_in_2),
    .data_in_3 (data_in_3),
    .data_in_4 (data_in_4),
    .grant     (grant),
    .selector  (selector),
    .bus_valid (bus_valid),
    .bus_data  (bus_data),
    .hold_cnt  (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock, then check the per-cycle invariants away from the edge.
  task automatic tick();
    logic [4:0] g;
    @(posedge clk);
    #1;
    g = grant;
    checks++;
    if ((g & (g - 5'd1)) !== 5'd0) begin
      failures++;
      $display("FAIL onehot grant=%b", g);
    end
    checks++;
    if (bus_valid !== (|g)) begin
      failures++;
      $display("FAIL valid_vs_grant bus_valid=%b grant=%b", bus_valid, g);
    end
    checks++;
    if (selector > 3'd4) begin
      failures++;
      $display("FAIL sel_range selector=%0d required<=4", selector);
    end else if (bus_data !== exp_data[selector]) begin
      failures++;
      $display("FAIL mux bus_data=%h required=%h", bus_data, exp_data[selector]);
    end
  endtask

  task automatic do_reset();
    req     = 5'd0;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [4:0] eg, input logic [2:0] es,
                           input logic ev, input logic [7:0] eh);
    checks++;
    if (grant !== eg || selector !== es || bus_valid !== ev || hold_cnt !== eh) begin
      failures++;
      $display("FAIL %s got g=%b s=%0d v=%b h=%0d required g=%b s=%0d v=%b h=%0d",
               name, grant, selector, bus_valid, hold_cnt, eg, es, ev, eh);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_out("reset", 5'b00000, 3'd0, 1'b0, 8'd0);
    checks++;
    if (bus_data !== exp_data[0]) begin
      failures++;
      $display("FAIL reset_data bus_data=%h required=%h", bus_data, exp_data[0]);
    end
  endtask

  task automatic test_first_grant();
    do_reset();
    req = 5'b00100;
    tick();
    check_out("first_grant", 5'b00100, 3'd2, 1'b1, 8'd1);
    checks++;
    if (bus_data !== exp_data[2]) begin
      failures++;
      $display("FAIL first_data bus_data=%h required=%h", bus_data, exp_data[2]);
    end
    req = 5'b00000;
    tick();
    check_out("release_switch", 5'b00000, 3'd2, 1'b0, 8'd0);
    tick();
    check_out("back_to_idle", 5'b00000, 3'd2, 1'b0, 8'd0);
  endtask

  task automatic test_rotation();
    int seq [6] = '{0, 1, 2, 3, 4, 0};
    logic [4:0] one;
    one = 5'b00001;
    do_reset();
    req = 5'b11111;
    tick();
    for (int o = 0; o < 6; o++) begin
      for (int h = 1; h <= 8; h++) begin
        check_out("rotate_hold", one << seq[o], 3'(seq[o]), 1'b1, 8'(h));
        tick();
      end
      if (o < 5) begin
        check_out("rotate_switch", 5'b00000, 3'(seq[o]), 1'b0, 8'd0);
        tick();
      end
    end
    req = 5'b00000;
  endtask

  task automatic test_saturate();
    do_reset();
    req = 5'b01000;
    for (int c = 1; c <= 20; c++) begin
      tick();
      check_out("saturate", 5'b01000, 3'd3, 1'b1, (c > 8) ? 8'd8 : 8'(c));
    end
    req = 5'b00000;
  endtask

  task automatic test_release_race();
    do_reset();
    req = 5'b00010;
    tick();
    check_out("race_own1", 5'b00010, 3'd1, 1'b1, 8'd1);
    tick();
    req = 5'b00001;
    tick();
    check_out("race_switch", 5'b00000, 3'd1, 1'b0, 8'd0);
    tick();
    check_out("race_wrap0", 5'b00001, 3'd0, 1'b1, 8'd1);
    req = 5'b00000;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 5'b10000;
    for (int c = 0; c < 5; c++) tick();
    check_out("mid_hold5", 5'b10000, 3'd4, 1'b1, 8'd5);
    #2;
    reset_n = 1'b0;
    #1;
    check_out("async_reset", 5'b00000, 3'd0, 1'b0, 8'd0);
    req = 5'b10001;
    #2;
    reset_n = 1'b1;
    tick();
    check_out("post_reset_prio", 5'b00001, 3'd0, 1'b1, 8'd1);
    req = 5'b00000;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    data_in_0 = 32'hA000_0000;
    data_in_1 = 32'hB111_1111;
    data_in_2 = 32'hC222_2222;
    data_in_3 = 32'hD333_3333;
    data_in_4 = 32'hE444_4444;
    exp_data[0] = 32'hA000_0000;
    exp_data[1] = 32'hB111_1111;
    exp_data[2] = 32'hC222_2222;
    exp_data[3] = 32'hD333_3333;
    exp_data[4] = 32'hE444_4444;
    req     = 5'd0;
    reset_n = 1'b0;
    test_reset();
    test_first_grant();
    test_rotation();
    test_saturate();
    test_release_race();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/src_bus_arbiter.md
Name: src_bus_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit bus among 5 requesters.
- Drives the 3-bit selector of a 5:1 32-bit source mux. Selector codes 0..3 pick inputs one..four; code 4 picks input five.
- Sits between the multicycle datapath sources (PC, ALU out, MDR, shift result, immediate) and a single shared write/transfer bus.
- Adds a bounded ownership time and a one-cycle turnaround between owners.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles before preemption when others are waiting. Legal range 1..255.
- DATA_W, 32, width of each source and of bus_data.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  5  level request per requester; bit i = requester i.
- data_in_0 .. data_in_4  input  DATA_W each  source data per requester.
- grant  output  5  one-hot registered grant; all-zero when no owner.
- selector  output  3  registered mux select, binary index of owner.
- bus_valid  output  1  high while an owner holds the bus.
- bus_data  output  DATA_W  mux output; data_in[selector], combinational from selector.
- hold_cnt  output  8  cycles the current owner has held the bus.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State IDLE; grant=0, selector=0, bus_valid=0, hold_cnt=0.
  - Internal last_owner=4, so requester 0 has first priority.
- Round-robin pick:
  - Search starts at last_owner+1 mod 5 and wraps 4 -> 0; the first set req bit wins.
  - The previous owner has lowest priority.
- IDLE:
  - If req != 0 in cycle N, go to GRANT. In cycle N+1: grant one-hot of winner, selector=winner index, bus_valid=1, hold_cnt=1.
  - If req == 0, stay in IDLE; outputs unchanged.
- GRANT, evaluated each cycle in priority order:
  - (a) req[owner]=0: go to SWITCH (voluntary release).
  - (b) hold_cnt==MAX_HOLD and any other req bit set: go to SWITCH (preemption).
  - (c) Otherwise stay in GRANT; hold_cnt increments, saturating at MAX_HOLD.
  - With MAX_HOLD reached and no other requester, the owner keeps the bus indefinitely at hold_cnt=MAX_HOLD.
- SWITCH (exactly one cycle):
  - grant=0, bus_valid=0, hold_cnt=0.
  - selector holds the old value; no bus glitch to another source during turnaround.
  - last_owner is updated to the departing owner.
  - Arbitration runs on req sampled in this cycle: any set bit goes to GRANT with the new winner next cycle; none goes to IDLE.
  - The departing owner may be re-granted if it is the only requester.
- Invariants:
  - grant is zero or one-hot, never multi-hot.
  - bus_valid == |grant.
  - selector is 0..4 only; codes 5..7 never driven.
- Simultaneous events:
  - Release and preemption in the same cycle are both treated as SWITCH; one turnaround only.
  - A new request arriving in the same cycle the owner releases takes part in the SWITCH arbitration.
- Reset mid-grant: outputs drop to reset values immediately (async). After release, requester 0 has priority again.
- Worst-case wait for a continuously requesting input: 4*(MAX_HOLD+1) cycles.

Decomposition:
- Shared package:
  - state encoding (IDLE=2'd0, GRANT=2'd1, SWITCH=2'd2);
  - NUM_SRC=5;
  - selector codes SEL_SRC0..SEL_SRC4 = 3'd0..3'd4.
- Sub-module src_mux5: purely combinational 5:1 DATA_W mux producing bus_data from selector.
- Arbiter FSM, round-robin pick function and hold counter stay in src_bus_arbiter.

Test Plan:
- Reset then req=5'b00100 in cycle 0 -> cycle 1: grant=5'b00100, selector=2, bus_valid=1, hold_cnt=1, bus_data=data_in_2.
- req=5'b11111 held constant, MAX_HOLD=8:
  - owners rotate 0,1,2,3,4,0;
  - each holds exactly 8 cycles, then 1 SWITCH cycle with bus_valid=0 and selector unchanged.
- Owner 3 sole requester for 20 cycles, MAX_HOLD=8 -> no SWITCH; hold_cnt saturates at 8; grant stays 5'b01000.
- Owner 1 drops req in the same cycle req[0] rises -> next cycle SWITCH; following cycle grant=5'b00001, because requester 0 is the only request and wraps around past the departing owner.
- reset_n pulsed low while owner 4 holds at hold_cnt=5 -> outputs zero asynchronously. After release with req=5'b10001, grant=5'b00001.
- Assertions every cycle:
  - grant is one-hot or zero;
  - bus_valid==|grant;
  - selector<=4;
  - bus_data==data_in[selector].
